// File: rtl/main_slave_port_driver_if.sv
// Bundle between main_slave_port_driver (master modport) and its surroundings (slave modport):
// command/response channel, HLS slave memory port, and start/done handshake.
interface main_slave_port_driver_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 64,
  parameter int SIZE_W = 7,
  parameter int CNT_W  = 32
);
  // Command channel: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // the offerer holds cmd_* stable while cmd_valid is high and ready is low.
  // rsp_valid is a single-cycle pulse with no back-pressure.
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [DATA_W-1:0]     cmd_wdata;
  logic [SIZE_W-1:0]     cmd_size;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic [CNT_W-1:0]      rsp_cycles;
  logic                  rsp_err;
  logic [1:0]            S_oe_ram;
  logic [1:0]            S_we_ram;
  logic [2*ADDR_W-1:0]   S_addr_ram;
  logic [2*DATA_W-1:0]   S_Wdata_ram;
  logic [2*SIZE_W-1:0]   S_data_ram_size;
  logic [2*DATA_W-1:0]   Sout_Rdata_ram;
  logic [1:0]            Sout_DataRdy;
  logic                  start_port;
  logic                  done_port;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_size,
    input  Sout_Rdata_ram, Sout_DataRdy, done_port,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_cycles, rsp_err,
    output S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size, start_port
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_size,
    output Sout_Rdata_ram, Sout_DataRdy, done_port,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_cycles, rsp_err,
    input  S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size, start_port
  );
endinterface

// File: rtl/main_slave_port_driver.sv
// Single-beat command initiator for the HLS slave memory port plus start/done run timer.
// Define SLAVE_DRV_TIMEOUT_EN to abort slave accesses that see no DataRdy within TIMEOUT cycles.
module main_slave_port_driver #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 64,
  parameter int SIZE_W  = 7,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  main_slave_port_driver_if.master bus,
  output logic [2:0]               dbg_state
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    START  = 3'd2,
    RUN    = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_RUN   = 2'd2;

  state_t              state_q, state_d;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [SIZE_W-1:0]   size_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cycles_q;
  logic                err_q;
  logic                accept;
  logic                in_access;
  logic                access_done;
  logic                access_abort;
  logic [DATA_W-1:0]   size_mask;
  logic                unused_inputs;

  assign accept      = bus.cmd_valid && (state_q == IDLE);
  assign in_access   = (state_q == ACCESS);
  assign access_done = in_access && bus.Sout_DataRdy[0];
  assign unused_inputs = ^{bus.Sout_Rdata_ram[2*DATA_W-1:DATA_W], bus.Sout_DataRdy[1]};

  // Keep the low cmd_size bits of the returned word; sizes >= DATA_W pass everything.
  always_comb begin
    size_mask = '0;
    for (int i = 0; i < DATA_W; i++) size_mask[i] = (i < int'(size_q));
  end

`ifdef SLAVE_DRV_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q;

  always_ff @(posedge clock) begin
    if (reset || !in_access) tmo_q <= '0;
    else                     tmo_q <= tmo_q + 1'b1;
  end

  assign access_abort = in_access && !bus.Sout_DataRdy[0] && (tmo_q == TMO_W'(TIMEOUT - 1));
`else
  localparam int unused_timeout = TIMEOUT;
  assign access_abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.cmd_op == OP_WRITE || bus.cmd_op == OP_READ) state_d = ACCESS;
          else if (bus.cmd_op == OP_RUN)                       state_d = START;
          else                                                 state_d = RESP;
        end
      end
      ACCESS:  if (access_done || access_abort) state_d = RESP;
      START:   state_d = bus.done_port ? RESP : RUN;
      RUN:     if (bus.done_port) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      cycles_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= bus.cmd_op;
        addr_q   <= bus.cmd_addr;
        wdata_q  <= bus.cmd_wdata;
        size_q   <= bus.cmd_size;
        rdata_q  <= '0;
        cycles_q <= '0;
        err_q    <= (bus.cmd_op == 2'd3);
        cnt_q    <= CNT_W'(1);  // the start cycle itself counts as cycle 1
      end
      if (access_done && op_q == OP_READ) rdata_q <= bus.Sout_Rdata_ram[DATA_W-1:0] & size_mask;
      if (access_abort) err_q <= 1'b1;
      if (state_q == START || state_q == RUN) begin
        if (bus.done_port)   cycles_q <= cnt_q;
        else if (cnt_q != '1) cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.cmd_ready       = (state_q == IDLE);
  assign bus.rsp_valid       = (state_q == RESP);
  assign bus.rsp_rdata       = bus.rsp_valid ? rdata_q  : '0;
  assign bus.rsp_cycles      = bus.rsp_valid ? cycles_q : '0;
  assign bus.rsp_err         = bus.rsp_valid && err_q;
  assign bus.S_oe_ram        = {1'b0, in_access && (op_q == OP_READ)};
  assign bus.S_we_ram        = {1'b0, in_access && (op_q == OP_WRITE)};
  assign bus.S_addr_ram      = {{ADDR_W{1'b0}}, in_access ? addr_q  : {ADDR_W{1'b0}}};
  assign bus.S_Wdata_ram     = {{DATA_W{1'b0}}, in_access ? wdata_q : {DATA_W{1'b0}}};
  assign bus.S_data_ram_size = {{SIZE_W{1'b0}}, in_access ? size_q  : {SIZE_W{1'b0}}};
  assign bus.start_port      = (state_q == START);
  assign dbg_state           = state_q;
endmodule

// File: tb/tb_main_slave_port_driver.sv
// Bench for main_slave_port_driver: directed vector table, reset/long-wait sequences,
// and random commands scored against a memory/run-length reference model.
module tb_main_slave_port_driver;
  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 64;
  localparam int SIZE_W  = 7;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 16;
  localparam int LAT_W   = 16;
  localparam int RSP_W   = LAT_W + 1 + CNT_W + DATA_W;
  localparam logic [1:0] OP_WRITE = 2'd0, OP_READ = 2'd1, OP_RUN = 2'd2, OP_RSV = 2'd3;

  logic       clock;
  logic       reset;
  logic [2:0] dbg_state;

  main_slave_port_driver_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .CNT_W(CNT_W)) bus ();

  main_slave_port_driver #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  int unsigned cyc = 0;
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];

  function automatic logic [DATA_W-1:0] dflt(input logic [ADDR_W-1:0] a);
    return 64'hC0DE_5A5A_0000_0000 | DATA_W'(a);
  endfunction

  function automatic logic [DATA_W-1:0] mask_of(input int s);
    if (s >= DATA_W) return '1;
    return (64'd1 << s) - 64'd1;
  endfunction

  function automatic logic [RSP_W-1:0] model(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                                             input logic [DATA_W-1:0] wd, input logic [SIZE_W-1:0] sz,
                                             input int wt, input int rl);
    logic [DATA_W-1:0] rd = '0;
    logic              err = 1'b0;
    logic [CNT_W-1:0]  runc = '0;
    int                lat;
    case (op)
      OP_WRITE: begin ref_mem[a] = wd; lat = wt + 3; end
      OP_READ: begin
        rd  = (ref_mem.exists(a) ? ref_mem[a] : dflt(a)) & mask_of(int'(sz));
        lat = wt + 3;
      end
      OP_RUN: begin runc = CNT_W'(rl); lat = rl + 2; end
      default: begin err = 1'b1; lat = 2; end
    endcase
    return {LAT_W'(lat), err, runc, rd};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [RSP_W-1:0] exp_q[$];
  logic [RSP_W-1:0] mon_exp, mon_got;
  int unsigned acc_cyc = 0;
  int en_cycles = 0, starts = 0, rsp_seen = 0, ch1_viol = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (bus.rsp_valid) begin
        rsp_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL rsp_unexpected: rsp_valid with nothing pending (cycle %0d)", cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_got = {LAT_W'(cyc - acc_cyc + 1), bus.rsp_err, bus.rsp_cycles, bus.rsp_rdata};
          check("rsp{lat,err,cycles,rdata}", mon_got, mon_exp);
        end
      end
      if (bus.S_oe_ram[0] || bus.S_we_ram[0]) en_cycles++;
      if (bus.start_port) starts++;
      if (bus.S_oe_ram[1] || bus.S_we_ram[1] || (|bus.S_addr_ram[2*ADDR_W-1:ADDR_W]) ||
          (|bus.S_Wdata_ram[2*DATA_W-1:DATA_W]) || (|bus.S_data_ram_size[2*SIZE_W-1:SIZE_W]))
        ch1_viol++;
    end
  end

  // ---------------- slave memory and main stubs ----------------
  int  slave_wait  = 0;  // -1: never ready
  int  run_len     = 1;
  bit  slave_noise = 1'b0;
  int  acc_cnt     = 0;
  int  run_rem     = -1;
  logic [DATA_W-1:0]   slv_mem [logic [ADDR_W-1:0]];
  logic [ADDR_W-1:0]   slv_a;
  logic [2*ADDR_W-1:0] last_addr;
  logic [2*SIZE_W-1:0] last_size;
  logic [2*DATA_W-1:0] last_wdata;

  always @(negedge clock) begin
    bus.Sout_DataRdy   = 2'b00;
    bus.Sout_Rdata_ram = {$urandom, $urandom, $urandom, $urandom};
    if (bus.S_oe_ram[0] || bus.S_we_ram[0]) begin
      if (slave_wait >= 0 && acc_cnt >= slave_wait) begin
        bus.Sout_DataRdy = {1'($urandom_range(0, 1)), 1'b1};
        last_addr  = bus.S_addr_ram;
        last_size  = bus.S_data_ram_size;
        last_wdata = bus.S_Wdata_ram;
        slv_a      = bus.S_addr_ram[ADDR_W-1:0];
        if (bus.S_we_ram[0]) slv_mem[slv_a] = bus.S_Wdata_ram[DATA_W-1:0];
        bus.Sout_Rdata_ram[DATA_W-1:0] = slv_mem.exists(slv_a) ? slv_mem[slv_a] : dflt(slv_a);
        acc_cnt = 0;
      end else begin
        acc_cnt++;
      end
    end else begin
      acc_cnt = 0;
      if (slave_noise && $urandom_range(0, 3) == 0) bus.Sout_DataRdy = 2'b01;
    end
  end

  always @(negedge clock) begin
    bus.done_port = 1'b0;
    if (bus.start_port)   run_rem = run_len - 1;
    else if (run_rem > 0) run_rem--;
    if (run_rem == 0) begin
      bus.done_port = 1'b1;
      run_rem = -1;
    end else if (run_rem < 0 && !bus.start_port && slave_noise && $urandom_range(0, 5) == 0) begin
      bus.done_port = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                          input logic [SIZE_W-1:0] sz, input int wt, input int rl,
                          input bit push, input logic [RSP_W-1:0] exp);
    int t = 0;
    @(negedge clock);
    while (!bus.cmd_ready && t < 2000) begin
      @(negedge clock);
      t++;
    end
    if (!bus.cmd_ready) begin
      n_checks++;
      $display("FAIL cmd_ready_timeout: cmd_ready=%0b after %0d cycles", bus.cmd_ready, t);
      return;
    end
    slave_wait    = wt;
    run_len       = rl;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_wdata = wd;
    bus.cmd_size  = sz;
    acc_cyc       = cyc;
    if (push) exp_q.push_back(exp);
    @(posedge clock);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom);
    bus.cmd_addr  = ADDR_W'($urandom);
    bus.cmd_wdata = {$urandom, $urandom};
    bus.cmd_size  = SIZE_W'($urandom);
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge clock);
      t++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d responses still pending after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic reset_during_access(input int hold);
    int base_en, base_rsp;
    send_cmd(OP_READ, 9'h040, '0, 7'd32, -1, 1, 1'b0, '0);
    base_en = en_cycles;
    repeat (hold) @(negedge clock);
    #1;
    check("long_wait_oe_held", bus.S_oe_ram, 2'b01);
    check("long_wait_oe_cycles", en_cycles - base_en, hold);
    reset    = 1'b1;
    base_rsp = rsp_seen;
    @(negedge clock);
    check("rst_mid_enables_low", {bus.S_oe_ram, bus.S_we_ram}, 4'b0000);
    check("rst_mid_cmd_ready", bus.cmd_ready, 1'b1);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    #1;
    check("rst_mid_no_rsp", rsp_seen - base_rsp, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SIZE_W-1:0] size;
    int                wt;
    int                rl;
    logic [DATA_W-1:0] e_rdata;
    logic              e_err;
    logic [CNT_W-1:0]  e_cycles;
    int                e_lat;
    int                e_en;
    int                e_starts;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];
  logic [SIZE_W-1:0] sizes [4] = '{7'd8, 7'd16, 7'd32, 7'd64};

  initial begin
    int base_en, base_st, r, wt, rl;
    logic [1:0]        op;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    logic [SIZE_W-1:0] sz;

    //         op        addr    wdata                    size  wt rl  rdata                    err cyc  lat en st
    vecs[0] = '{OP_WRITE, 9'h010, 64'h0000_0000_DEAD_BEEF, 7'd32, 2, 0, 64'h0,                   0, 0,   5,  3, 0};
    vecs[1] = '{OP_READ,  9'h010, 64'h0,                   7'd8,  0, 0, 64'hEF,                  0, 0,   3,  1, 0};
    vecs[2] = '{OP_READ,  9'h010, 64'h0,                   7'd16, 1, 0, 64'hBEEF,                0, 0,   4,  2, 0};
    vecs[3] = '{OP_WRITE, 9'h020, 64'h0123_4567_89AB_CDEF, 7'd64, 0, 0, 64'h0,                   0, 0,   3,  1, 0};
    vecs[4] = '{OP_READ,  9'h020, 64'h0,                   7'd32, 3, 0, 64'h89AB_CDEF,           0, 0,   6,  4, 0};
    vecs[5] = '{OP_READ,  9'h020, 64'h0,                   7'd64, 0, 0, 64'h0123_4567_89AB_CDEF, 0, 0,   3,  1, 0};
    vecs[6] = '{OP_RUN,   9'h000, 64'h0,                   7'd0,  0, 101, 64'h0,                 0, 101, 103, 0, 1};
    vecs[7] = '{OP_RUN,   9'h000, 64'h0,                   7'd0,  0, 1, 64'h0,                   0, 1,   3,  0, 1};
    vecs[8] = '{OP_RSV,   9'h010, 64'h0,                   7'd32, 0, 0, 64'h0,                   1, 0,   2,  0, 0};
    vecs[9] = '{OP_READ,  9'h1F8, 64'h0,                   7'd16, 0, 0, 64'h01F8,                0, 0,   3,  1, 0};

    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_size  = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_cmd_ready", bus.cmd_ready, 1'b1);
    check("reset_rsp_zero", |{bus.rsp_valid, bus.rsp_rdata, bus.rsp_cycles, bus.rsp_err}, 1'b0);
    check("reset_bus_zero", |{bus.S_oe_ram, bus.S_we_ram, bus.S_addr_ram, bus.S_Wdata_ram,
                              bus.S_data_ram_size, bus.start_port}, 1'b0);

    for (int i = 0; i < NV; i++) begin
      base_en = en_cycles;
      base_st = starts;
      send_cmd(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].wt, vecs[i].rl, 1'b1,
               {LAT_W'(vecs[i].e_lat), vecs[i].e_err, vecs[i].e_cycles, vecs[i].e_rdata});
      wait_drain(400);
      check($sformatf("vec%0d_enable_cycles", i), en_cycles - base_en, vecs[i].e_en);
      check($sformatf("vec%0d_start_pulses", i), starts - base_st, vecs[i].e_starts);
      if (vecs[i].op == OP_WRITE || vecs[i].op == OP_READ) begin
        check($sformatf("vec%0d_bus_addr", i), last_addr, {{ADDR_W{1'b0}}, vecs[i].addr});
        check($sformatf("vec%0d_bus_size", i), last_size, {{SIZE_W{1'b0}}, vecs[i].size});
      end
      if (vecs[i].op == OP_WRITE)
        check($sformatf("vec%0d_bus_wdata", i), last_wdata, {{DATA_W{1'b0}}, vecs[i].wdata});
    end
    // directed contents are now in the slave memory; mirror them in the model
    ref_mem[9'h010] = 64'h0000_0000_DEAD_BEEF;
    ref_mem[9'h020] = 64'h0123_4567_89AB_CDEF;

`ifdef SLAVE_DRV_TIMEOUT_EN
    base_en = en_cycles;
    send_cmd(OP_READ, 9'h048, '0, 7'd64, -1, 1, 1'b1, {LAT_W'(TIMEOUT + 2), 1'b1, CNT_W'(0), DATA_W'(0)});
    wait_drain(TIMEOUT + 50);
    check("timeout_oe_cycles", en_cycles - base_en, TIMEOUT);
    reset_during_access(8);
`else
    reset_during_access(1000);
`endif

    slave_noise = 1'b1;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      op = OP_WRITE;
      else if (r < 70) op = OP_READ;
      else if (r < 90) op = OP_RUN;
      else             op = OP_RSV;
      a = ($urandom_range(0, 4) == 0) ? ADDR_W'($urandom_range(0, 511)) : ADDR_W'($urandom_range(0, 7) * 8);
      wd = {$urandom, $urandom};
      sz = sizes[$urandom_range(0, 3)];
      wt = $urandom_range(0, 3);
      rl = $urandom_range(1, 24);
      send_cmd(op, a, wd, sz, wt, rl, 1'b1, model(op, a, wd, sz, wt, rl));
      if ($urandom_range(0, 1) == 1) wait_drain(200);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    wait_drain(400);
    slave_noise = 1'b0;

    check("ch1_always_zero", ch1_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
